// File: rtl/hit_judge.sv
// Hit/miss judge for the switch-and-light reaction game: latches a lane pattern,
// resolves hit/miss/timeout, keeps saturating scores. Optional `HIT_JUDGE_SYNC_EN.
module hit_judge #(
    parameter int N       = 8,
    parameter int TOKEN_W = 9,
    parameter int TIMEOUT = 1000,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       switch,
    input  logic [N-1:0]       light,
    input  logic               light_valid,
    output logic               armed,
    output logic               hit,
    output logic               miss,
    output logic               timeout,
    output logic [TOKEN_W-1:0] token,
    output logic               token_valid,
    output logic [SCORE_W-1:0] hit_count,
    output logic [SCORE_W-1:0] miss_count
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]      T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] SAT     = {SCORE_W{1'b1}};

    typedef enum logic {IDLE, ARMED} state_t;

    state_t             state;
    logic [N-1:0]       sw_in;
    logic [N-1:0]       switch_mem;
    logic [N-1:0]       target;
    logic [N-1:0]       toggled;
    logic [TW-1:0]      timer;
    logic [TOKEN_W-1:0] tok_cnt;

`ifdef HIT_JUDGE_SYNC_EN
    logic [N-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
        end
    end

    assign sw_in = sync2;
`else
    assign sw_in = switch;
`endif

    assign toggled = sw_in ^ switch_mem;
    assign armed   = (state == ARMED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            switch_mem  <= '0;
            target      <= '0;
            timer       <= '0;
            tok_cnt     <= '0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            timeout     <= 1'b0;
            token       <= '0;
            token_valid <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            switch_mem  <= sw_in;
            tok_cnt     <= tok_cnt + TOKEN_W'(1);
            hit         <= 1'b0;
            miss        <= 1'b0;
            timeout     <= 1'b0;
            token_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // toggles seen here are dropped: switch_mem still tracks sw_in
                    if (light_valid) begin
                        target <= light;
                        timer  <= '0;
                        state  <= ARMED;
                    end
                end
                ARMED: begin
                    if (toggled != '0) begin
                        state       <= IDLE;
                        token       <= tok_cnt;
                        token_valid <= 1'b1;
                        if (toggled == target) begin
                            hit <= 1'b1;
                            if (hit_count != SAT) hit_count <= hit_count + SCORE_W'(1);
                        end else begin
                            miss <= 1'b1;
                            if (miss_count != SAT) miss_count <= miss_count + SCORE_W'(1);
                        end
                    end else if (timer == T_LAST) begin
                        state       <= IDLE;
                        token       <= tok_cnt;
                        token_valid <= 1'b1;
                        miss        <= 1'b1;
                        timeout     <= 1'b1;
                        if (miss_count != SAT) miss_count <= miss_count + SCORE_W'(1);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: directed rounds push expected resolutions,
// a negedge monitor pops and compares every pulse the DUT produces.
module tb_hit_judge;
    localparam int N       = 8;
    localparam int TOKEN_W = 9;
    localparam int TIMEOUT = 4;
    localparam int SCORE_W = 2;
`ifdef HIT_JUDGE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int                 cyc;
        logic               hit;
        logic               miss;
        logic               to;
        logic [TOKEN_W-1:0] tok;
        logic [SCORE_W-1:0] hc;
        logic [SCORE_W-1:0] mc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       sw = '0;
    logic [N-1:0]       light = '0;
    logic               light_valid = 1'b0;
    logic               armed, hit, miss, timeout, token_valid;
    logic [TOKEN_W-1:0] token;
    logic [SCORE_W-1:0] hit_count, miss_count;

    int   cyc = 0;
    int   rst_cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    int   hc_m = 0;
    int   mc_m = 0;
    exp_t sb[$];

    hit_judge #(.N(N), .TOKEN_W(TOKEN_W), .TIMEOUT(TIMEOUT), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .rst(rst), .switch(sw), .light(light), .light_valid(light_valid),
        .armed(armed), .hit(hit), .miss(miss), .timeout(timeout), .token(token),
        .token_valid(token_valid), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) rst_cyc = cyc;
    end

    always @(negedge clk) begin
        if (hit || miss || timeout || token_valid) begin
            vecs++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_pulse cyc=%0d got hit=%b miss=%b to=%b tv=%b, required none",
                         cyc, hit, miss, timeout, token_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || hit !== e.hit || miss !== e.miss || timeout !== e.to ||
                    token_valid !== 1'b1 || token !== e.tok || hit_count !== e.hc ||
                    miss_count !== e.mc) begin
                    errs++;
                    $display("FAIL resolution got cyc=%0d h=%b m=%b to=%b tv=%b tok=%0d hc=%0d mc=%0d, required cyc=%0d h=%b m=%b to=%b tv=1 tok=%0d hc=%0d mc=%0d",
                             cyc, hit, miss, timeout, token_valid, token, hit_count, miss_count,
                             e.cyc, e.hit, e.miss, e.to, e.tok, e.hc, e.mc);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        vecs++;
        if (got != req) begin
            errs++;
            $display("FAIL %s got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // light_valid driven in the current cycle t; lanes m flipped in cycle t+d (m==0: no flip)
    task automatic round(input logic [N-1:0] l, input logic [N-1:0] m, input int d, input bit hold);
        int   t;
        exp_t e;
        t = cyc;
        if (m != '0 && d + LAT - 1 <= TIMEOUT) begin
            e.cyc = t + d + LAT;
            e.hit = (m == l);
            e.to  = 1'b0;
        end else begin
            e.cyc = t + 1 + TIMEOUT;
            e.hit = 1'b0;
            e.to  = 1'b1;
        end
        e.miss = !e.hit;
        if (e.hit) hc_m = (hc_m < 3) ? hc_m + 1 : 3;
        else       mc_m = (mc_m < 3) ? mc_m + 1 : 3;
        e.hc  = SCORE_W'(hc_m);
        e.mc  = SCORE_W'(mc_m);
        e.tok = TOKEN_W'(e.cyc - 1 - rst_cyc);
        sb.push_back(e);
        light = l;
        light_valid = 1'b1;
        for (int k = 1; t + k <= e.cyc; k++) begin
            tick();
            if (k == 1) check("armed_after_lv", int'(armed), 1);
            light_valid = hold && (t + k < e.cyc);
            light = ~l;
            if (m != '0 && k == d) sw = sw ^ m;
        end
        light_valid = 1'b0;
        check("armed_after_resolve", int'(armed), 0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        // idle with switch activity: nothing may resolve
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) sw = sw ^ N'(i + 1);
            tick();
            if (i % 5 == 4) begin
                check("idle_armed", int'(armed), 0);
                check("idle_token", int'(token), 0);
                check("idle_hit_count", int'(hit_count), 0);
                check("idle_miss_count", int'(miss_count), 0);
            end
        end
        repeat (3) tick();

        round(8'h10, 8'h10, 1, 1'b0);                     // single-lane hit
        round(8'h10, 8'h08, 2, 1'b0);                     // wrong lane
        round(8'h05, 8'h05, 1, 1'b0);                     // two-lane hit
        round(8'h05, 8'h01, 1, 1'b0);                     // partial toggle
        round(8'h22, 8'h00, 0, 1'b0);                     // timeout
        round(8'h40, 8'h40, TIMEOUT - LAT + 1, 1'b0);     // toggle in last armed cycle
        round(8'h80, 8'h80, 1, 1'b1);                     // light_valid held while armed
        round(8'h01, 8'h01, 2, 1'b0);
        round(8'h02, 8'h02, 1, 1'b0);                     // hit score saturated
        round(8'h00, 8'h01, 1, 1'b0);                     // zero target: miss
        round(8'h00, 8'h00, 0, 1'b0);                     // miss score saturated
        check("sat_hit_count", int'(hit_count), 3);
        check("sat_miss_count", int'(miss_count), 3);

        // reset in the middle of an armed round
        light = 8'h08;
        light_valid = 1'b1;
        tick();
        light_valid = 1'b0;
        check("armed_pre_reset", int'(armed), 1);
        tick();
        rst = 1'b1;
        hc_m = 0;
        mc_m = 0;
        tick();
        rst = 1'b0;
        check("reset_armed", int'(armed), 0);
        check("reset_hit_count", int'(hit_count), 0);
        check("reset_miss_count", int'(miss_count), 0);
        repeat (4) tick();
        round(8'h08, 8'h08, 1, 1'b0);

        repeat (8) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d, required test end", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hit_judge.md
# hit_judge

Parametrised hit/miss judge for the switch-and-light reaction game. It latches an N-lane target light pattern when a round is presented, then watches the player's switches for a toggle. It resolves each round as a hit (exactly the lit lanes toggled), a miss (wrong lanes toggled), or a timeout. It keeps saturating hit/miss scores and hands a fresh token to the randomizer at every resolution.

## Interface
- `N`, 8, lane count (switch/light width), ≥1
- `TOKEN_W`, 9, token width
- `TIMEOUT`, 1000, max cycles a round stays armed, ≥2
- `SCORE_W`, 8, hit/miss counter width

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `switch`  in  N  player switch levels
- `light`  in  N  target pattern from randomizer
- `light_valid`  in  1  new target presented; accepted only in IDLE
- `armed`  out  1  round in progress (state == ARMED)
- `hit`  out  1  one-cycle pulse: round resolved as hit
- `miss`  out  1  one-cycle pulse: round resolved as wrong-switch or timeout
- `timeout`  out  1  one-cycle pulse, coincident with `miss`, when the cause was timeout
- `token`  out  TOKEN_W  seed for randomizer, updated at each resolution
- `token_valid`  out  1  one-cycle pulse, coincident with `hit` or `miss`
- `hit_count`  out  SCORE_W  saturating hit score
- `miss_count`  out  SCORE_W  saturating miss score

## Operation
- Reset: state IDLE. All outputs, `target`, `switch_mem`, timer and free-running token counter are 0.
- `switch_mem` registers `switch` every cycle in all states.
  - `toggled = switch ^ switch_mem` (combinational).
  - Toggles in IDLE are absorbed and never carried into a round.
- Free-running `tok_cnt` (TOKEN_W) increments every cycle and wraps to 0.
- FSM states:
  - IDLE: if `light_valid`, then `target <= light`, timer ← 0, go to ARMED.
  - ARMED: evaluated each cycle in this priority order.
    1. `toggled != 0` and `toggled == target`: resolve as hit.
    2. `toggled != 0` and `toggled != target`: resolve as miss.
    3. Timer == TIMEOUT-1: resolve as miss with timeout.
    4. Otherwise timer increments.
  - `light_valid` in ARMED is ignored.
- Resolution (registered, takes effect next cycle):
  - State goes to IDLE.
  - `token <= tok_cnt`; `token_valid`=1.
  - Exactly one of `hit`/`miss` is 1; `timeout` is set only for cause 3.
  - The corresponding counter increments and saturates at 2^SCORE_W-1.
- Multi-lane targets: a hit requires all target lanes to toggle in the same cycle with no extra lanes. A partial toggle is a miss.
- `target == 0`: no toggle can match, so the round ends as a miss (wrong switch or timeout).
- Pulses (`hit`, `miss`, `timeout`, `token_valid`) are 0 in every non-resolution cycle.

## Timing
- `light_valid` sampled in cycle t (IDLE): `armed`=1 from t+1. Timer=0 at t+1.
- Toggle first visible at `switch` in cycle c (ARMED): `hit`/`miss` high in c+1, `armed`=0 in c+1.
- Without a toggle, a round armed at t+1 times out with `miss`/`timeout` in cycle t+1+TIMEOUT.
- A toggle in the final armed cycle beats timeout (priority 1/2 over 3).
- A new `light_valid` is accepted in the resolution cycle itself (state already IDLE), so rounds can issue back-to-back every 2 cycles minimum.
- `rst` mid-round: FSM goes to IDLE next edge, no pulse issued, scores cleared.
- Adding `HIT_JUDGE_SYNC_EN` adds exactly 2 cycles to toggle-to-response latency. Timeout latency is unchanged.

## Configuration
- `HIT_JUDGE_SYNC_EN` defined:
  - `switch` passes through a 2-flop synchronizer before `switch_mem`/`toggled`.
  - Synchronizer flops reset to 0. The first post-reset switch levels therefore appear as a toggle in IDLE and are absorbed.
- Undefined: `switch` is used directly; intended for benches and already-synchronous sources.

## Test plan
- Reset then idle 20 cycles: all outputs 0, `token` 0, `armed` 0. Switch toggles in IDLE produce no pulse.
- N=8, `light`=8'h10 with `light_valid` at t; flip switch bit 4 at c: `hit`+`token_valid` at c+1, `hit_count`=1, `token`=tok_cnt value at c.
- `light`=8'h10; flip bit 3: `miss` at c+1, `timeout`=0, `miss_count`=1. Then target 8'h05 with bits 0 and 2 flipped together: `hit`. Target 8'h05 with only bit 0 flipped: `miss`.
- TIMEOUT=4, arm at t, no toggle: `miss`+`timeout` at t+5. Toggling the correct lane exactly at t+4 gives `hit` at t+5 instead.
- SCORE_W=2: five consecutive hits leave `hit_count`=3. A `light_valid` held high in ARMED is not re-latched. `rst` asserted mid-round returns to IDLE with no pulse.
- With `HIT_JUDGE_SYNC_EN`: the same hit stimulus responds at c+3.
